// File: rtl/scr1_tb_ahb_slave_if.sv
// AHB-Lite slave front-end for the testbench memory model.
// Decodes address/data phases, inserts wait states from a rotating stall
// pattern, returns two-cycle ERROR responses and issues single-cycle SRAM
// requests. Define SCR1_TB_AHB_PROT_CHECK_EN to add the protocol checker
// and its prot_err_cnt output.
//
// state | meaning
// IDLE  | no transfer in data phase, ready for an address phase
// DATA  | data phase of an accepted transfer, completes when pattern[0]=1
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high), address phase ignored
module scr1_tb_ahb_slave_if #(
  parameter int AHB_AW         = 32,
  parameter int AHB_DW         = 32,
  parameter int MEM_POWER_SIZE = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               stall_pattern_in,
  input  logic [2:0]                hsize,
  input  logic [1:0]                htrans,
  input  logic [AHB_AW-1:0]         haddr,
  input  logic                      hwrite,
  input  logic [AHB_DW-1:0]         hwdata,
  output logic                      hready,
  output logic [AHB_DW-1:0]         hrdata,
  output logic                      hresp,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_POWER_SIZE-1:0] mem_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
`ifdef SCR1_TB_AHB_PROT_CHECK_EN
  ,
  output logic [15:0]               prot_err_cnt
`endif
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [31:0]               pattern;
  logic [MEM_POWER_SIZE-1:0] addr_q;
  logic [1:0]                size_q;
  logic                      write_q;
  logic [AHB_DW-1:0]         hrdata_q;

  logic                      accept;
  logic                      complete;
  logic                      req_err;
  logic                      addr_oor;
  logic                      misalign;
  logic [3:0]                be_calc;

  // Address-phase legality: size, alignment and range.
  assign addr_oor = (haddr >> MEM_POWER_SIZE) != '0;
  assign misalign = ((hsize == 3'd1) && haddr[0]) ||
                    ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign req_err  = (hsize > 3'd2) || misalign || addr_oor;

  // Next-state and handshake outputs; a completing data phase may accept
  // the next address phase so back-to-back transfers pipeline.
  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = 1'b0;
    complete  = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = htrans[1];
      end
      ST_DATA: begin
        hready = pattern[0];
        if (pattern[0]) begin
          complete  = 1'b1;
          accept    = htrans[1];
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      state_nxt = req_err ? ST_ERR1 : ST_DATA;
    end
  end

  // Byte-lane enables from the captured size and low address bits.
  always_comb begin
    be_calc = 4'b1111;
    case (size_q)
      2'd0:    be_calc = 4'b0001 << addr_q[1:0];
      2'd1:    be_calc = 4'b0011 << {addr_q[1], 1'b0};
      default: be_calc = 4'b1111;
    endcase
  end

  // Memory request port; gating with rst_n keeps an abandoned data phase
  // from reaching the array while reset is asserted.
  always_comb begin
    mem_req   = complete & rst_n;
    mem_we    = mem_req & write_q;
    mem_be    = mem_req ? be_calc : 4'b0000;
    mem_addr  = {addr_q[MEM_POWER_SIZE-1:2], 2'b00};
    mem_wdata = hwdata;
    if (mem_req) begin
      hrdata = write_q ? '0 : mem_rdata;
    end else begin
      hrdata = hrdata_q;
    end
  end

  // State, stall pattern, captured address phase and held read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pattern  <= (stall_pattern_in == 32'd0) ? 32'hFFFF_FFFF : stall_pattern_in;
      addr_q   <= '0;
      size_q   <= 2'd0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DATA) begin
        pattern <= {pattern[0], pattern[31:1]};
      end
      if (accept) begin
        addr_q  <= haddr[MEM_POWER_SIZE-1:0];
        size_q  <= hsize[1:0];
        write_q <= hwrite;
      end
      if (mem_req && !write_q) begin
        hrdata_q <= mem_rdata;
      end
    end
  end

`ifdef SCR1_TB_AHB_PROT_CHECK_EN
  logic [AHB_AW-1:0] prev_haddr;
  logic              prev_hwrite;
  logic [2:0]        prev_hsize;
  logic [1:0]        prev_htrans;
  logic              prev_hready;
  logic              viol_busy;
  logic              viol_chg;
  logic              viol_seq;

  // Master-side protocol violations observed this cycle.
  always_comb begin
    viol_busy = (htrans == HTRANS_BUSY);
    viol_chg  = !prev_hready && prev_htrans[1] && htrans[1] &&
                ((haddr != prev_haddr) || (hwrite != prev_hwrite) ||
                 (hsize != prev_hsize));
    viol_seq  = (prev_htrans == HTRANS_IDLE) && (htrans == HTRANS_SEQ);
  end

  // Previous-cycle bus snapshot and saturating violation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_haddr   <= '0;
      prev_hwrite  <= 1'b0;
      prev_hsize   <= 3'd0;
      prev_htrans  <= HTRANS_IDLE;
      prev_hready  <= 1'b1;
      prot_err_cnt <= 16'd0;
    end else begin
      prev_haddr  <= haddr;
      prev_hwrite <= hwrite;
      prev_hsize  <= hsize;
      prev_htrans <= htrans;
      prev_hready <= hready;
      if ((viol_busy || viol_chg || viol_seq) && (prot_err_cnt != 16'hFFFF)) begin
        prot_err_cnt <= prot_err_cnt + 16'd1;
      end
      if (viol_busy) $error("%0t: htrans=BUSY", $time);
      if (viol_chg)  $error("%0t: haddr/hwrite/hsize changed during wait state", $time);
      if (viol_seq)  $error("%0t: htrans=SEQ after IDLE", $time);
    end
  end
`endif

endmodule
